// File: rtl/rex_pkg.sv
// Shared state encoding and screen geometry for the runner game core and the pixel decider.
package rex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int REX_LEFT     = 8;
    localparam int REX_W        = 24;
    localparam int REX_H        = 23;
    localparam int OBST_W       = 16;
    localparam int OBST_H       = 22;
    localparam int SCREEN_H     = 64;
    localparam int REX_MAX_DOWN = 41;

    localparam logic [15:0] OBST_END = 16'hFFF0;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw jump/start button followed by a rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic press
);

    logic sync1, sync2, sync2_d;

    // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign press = sync2 & ~sync2_d;

endmodule

// File: rtl/rex_game_ctrl.sv
// Runner game core: button to game state, Rex height, obstacle position and score, stepped once per tick.
module rex_game_ctrl
    import rex_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int JUMP_V0    = 8,
    parameter int GRAVITY    = 1,
    parameter int OBST_START = 256,
    parameter int OBST_STEP  = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn,
    output logic [15:0] rex_down,
    output logic [15:0] obstacle_left,
    output logic [1:0]  game_state,
    output logic [15:0] score
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [15:0]        OBST_INIT  = 16'(OBST_START);
    localparam logic [15:0]        OBST_DELTA = 16'(OBST_STEP);
    localparam logic signed [15:0] REX_L      = 16'(REX_LEFT);
    localparam logic signed [15:0] REX_RIGHT  = 16'(REX_LEFT + REX_W);
    localparam logic signed [16:0] Y_ZERO     = 17'sd0;
    localparam logic signed [16:0] Y_MAX      = 17'(REX_MAX_DOWN);

    game_state_t       state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick, press, collide, grounded;
    logic              run_step, jump_arm, reload;
    logic              jump_pending;
    logic signed [7:0] vel, v_new;
    logic signed [16:0] y_sum;
    logic [15:0]       obst_right;

    btn_sync_edge u_btn (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tick_cnt <= '0;
        else
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
    end

    assign tick     = (tick_cnt == CNT_LAST);
    assign grounded = (rex_down == '0) && (vel == '0);

    // Rex spans x 8..31 and is tall enough to clear the obstacle once its bottom reaches OBST_H.
    assign obst_right = obstacle_left + 16'(OBST_W);
    assign collide    = ($signed(obstacle_left) < REX_RIGHT) && ($signed(obst_right) > REX_L)
                     && (rex_down < 16'(OBST_H));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press)   state_d = RUN;
            RUN:     if (collide) state_d = OVER;
            OVER:    if (press)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A collide takes priority over the tick, so the frame that collides is never moved.
    always_comb begin
        game_state = state_q;
        run_step   = 1'b0;
        jump_arm   = 1'b0;
        reload     = 1'b0;
        case (state_q)
            RUN: begin
                run_step = tick && !collide;
                jump_arm = press && grounded && !collide;
            end
            OVER:    reload = press;
            default: ;
        endcase
    end

    always_comb begin
        y_sum = {1'b0, rex_down};
        v_new = vel;
        if (jump_pending) begin
            y_sum = {1'b0, rex_down} + 17'(JUMP_V0);
            v_new = 8'(JUMP_V0 - GRAVITY);
        end else if (!grounded) begin
            y_sum = {1'b0, rex_down} + {{9{vel[7]}}, vel};
            v_new = vel - 8'(GRAVITY);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rex_down      <= '0;
            vel           <= '0;
            obstacle_left <= OBST_INIT;
            score         <= '0;
            jump_pending  <= 1'b0;
        end else if (reload) begin
            rex_down      <= '0;
            vel           <= '0;
            obstacle_left <= OBST_INIT;
            score         <= '0;
            jump_pending  <= 1'b0;
        end else begin
            if (run_step) begin
                if (y_sum <= Y_ZERO) begin
                    rex_down <= '0;
                    vel      <= '0;
                end else if (y_sum > Y_MAX) begin
                    rex_down <= 16'(REX_MAX_DOWN);
                    vel      <= v_new;
                end else begin
                    rex_down <= y_sum[15:0];
                    vel      <= v_new;
                end
                if (obstacle_left == OBST_END) begin
                    obstacle_left <= OBST_INIT;
                    score         <= score + 16'd1;
                end else begin
                    obstacle_left <= obstacle_left - OBST_DELTA;
                end
            end
            // A press landing on the tick that consumes a jump does not re-arm it.
            if (run_step && jump_pending)
                jump_pending <= 1'b0;
            else if (jump_arm)
                jump_pending <= 1'b1;
        end
    end

endmodule
